// File: rtl/load_store_unit_if.sv
// Bundle of the load/store unit's core-side request/response handshake and its RAM data-port
// signals.
//   req_*   : core -> LSU request (valid/ready), write flag, funct3, byte address, store data
//   resp_*  : LSU -> core response (valid/ready), extended load data, misaligned/fault flags
//   mem_*   : LSU -> RAM funct3, byte address, write data, write enable; RAM -> LSU read data
// The LSU connects through the slave modport; the core/RAM side connects through master.
interface load_store_unit_if #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [2:0]              req_funct3;
    logic [31:0]             req_addr;
    logic [SIZE-1:0]         req_wdata;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [SIZE-1:0]         resp_rdata;
    logic                    resp_misaligned;
    logic                    resp_fault;

    logic [2:0]              mem_funct3;
    logic [ADDR_WIDTH+1:0]   mem_address;
    logic [SIZE-1:0]         mem_w_data;
    logic                    mem_write;
    logic [SIZE-1:0]         mem_data_out;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
        output mem_funct3, mem_address, mem_w_data, mem_write
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
        input  mem_funct3, mem_address, mem_w_data, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer between the core memory stage and the data port of a byte-lane RAM
// with synchronous read. One request is in flight at a time: it is checked for alignment and
// range, drives the RAM for a single cycle, and for loads the registered read data is
// lane-extracted and sign/zero-extended before being returned over a valid/ready response.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.slave (request, response and RAM data-port signals)
module load_store_unit #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam int unsigned AW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

    state_e          state_q, state_d;
    logic            resp_valid_q, resp_valid_d;
    logic [SIZE-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_misaligned_q, resp_misaligned_d;
    logic            resp_fault_q, resp_fault_d;
    logic [2:0]      mem_funct3_q, mem_funct3_d;
    logic [AW-1:0]   mem_address_q, mem_address_d;
    logic [SIZE-1:0] mem_w_data_q, mem_w_data_d;
    logic            mem_write_q, mem_write_d;

    logic            req_illegal, req_misaligned, req_fault;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [SIZE-1:0] load_ext;

    // Request checks; only consulted while idle.
    always_comb begin
        if (bus.req_write) begin
            req_illegal = bus.req_funct3 > 3'd2;
        end else begin
            req_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 > 3'd5);
        end
        req_misaligned = req_illegal
            || ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0])
            || ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00));
        req_fault = |bus.req_addr[31:AW];
    end

    // Lane select and extension of the RAM word; mem_funct3/mem_address are still held from
    // the access, so they describe the load being captured.
    always_comb begin
        unique case (mem_address_q[1:0])
            2'd0: load_byte = bus.mem_data_out[7:0];
            2'd1: load_byte = bus.mem_data_out[15:8];
            2'd2: load_byte = bus.mem_data_out[23:16];
            2'd3: load_byte = bus.mem_data_out[31:24];
        endcase
        load_half = mem_address_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        unique case (mem_funct3_q[1:0])
            2'd0:    load_ext = {{24{~mem_funct3_q[2] & load_byte[7]}}, load_byte};
            2'd1:    load_ext = {{16{~mem_funct3_q[2] & load_half[15]}}, load_half};
            default: load_ext = bus.mem_data_out;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        resp_valid_d      = resp_valid_q;
        resp_rdata_d      = resp_rdata_q;
        resp_misaligned_d = resp_misaligned_q;
        resp_fault_d      = resp_fault_q;
        mem_funct3_d      = mem_funct3_q;
        mem_address_d     = mem_address_q;
        mem_w_data_d      = mem_w_data_q;
        mem_write_d       = mem_write_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (req_misaligned || req_fault) begin
                        // Rejected without touching the RAM.
                        resp_valid_d      = 1'b1;
                        resp_misaligned_d = req_misaligned;
                        resp_fault_d      = req_fault;
                        resp_rdata_d      = '0;
                        state_d           = StResp;
                    end else begin
                        mem_funct3_d  = bus.req_funct3;
                        mem_address_d = bus.req_addr[AW-1:0];
                        mem_w_data_d  = bus.req_wdata;
                        mem_write_d   = bus.req_write;
                        state_d       = StAccess;
                    end
                end
            end
            StAccess: begin
                // mem_write_q doubles as the store/load flag of the current request.
                mem_write_d = 1'b0;
                if (mem_write_q) begin
                    resp_rdata_d = '0;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                resp_rdata_d = load_ext;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (bus.resp_ready) begin
                    resp_valid_d      = 1'b0;
                    resp_misaligned_d = 1'b0;
                    resp_fault_d      = 1'b0;
                    state_d           = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= '0;
            resp_misaligned_q <= 1'b0;
            resp_fault_q      <= 1'b0;
            mem_funct3_q      <= '0;
            mem_address_q     <= '0;
            mem_w_data_q      <= '0;
            mem_write_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            resp_valid_q      <= resp_valid_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_misaligned_q <= resp_misaligned_d;
            resp_fault_q      <= resp_fault_d;
            mem_funct3_q      <= mem_funct3_d;
            mem_address_q     <= mem_address_d;
            mem_w_data_q      <= mem_w_data_d;
            mem_write_q       <= mem_write_d;
        end
    end

    assign bus.req_ready       = (state_q == StIdle);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_misaligned_q;
    assign bus.resp_fault      = resp_fault_q;
    assign bus.mem_funct3      = mem_funct3_q;
    assign bus.mem_address     = mem_address_q;
    assign bus.mem_w_data      = mem_w_data_q;
    assign bus.mem_write       = mem_write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural byte-lane RAM and an
// expected-response queue.
module tb_load_store_unit;
    localparam int unsigned SIZE       = 32;
    localparam int unsigned ADDR_WIDTH = 4;

    typedef struct {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        int          lat;
        int          wr;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   wr_cycles = 0;
    txn_t exp_q[$];

    bit [31:0] ram [16];
    bit [31:0] ram_rd;
    wire [ADDR_WIDTH-1:0] widx;

    load_store_unit_if #(.SIZE(SIZE), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    load_store_unit #(.SIZE(SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Byte-lane RAM, synchronous read of the addressed word (old data on collision).
    assign widx = bus.mem_address[ADDR_WIDTH+1:2];
    assign bus.mem_data_out = ram_rd;
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) begin
            case (bus.mem_funct3[1:0])
                2'd0: ram[widx][8*bus.mem_address[1:0] +: 8] <= bus.mem_w_data[7:0];
                2'd1: ram[widx][16*bus.mem_address[1] +: 16] <= bus.mem_w_data[15:0];
                default: ram[widx] <= bus.mem_w_data;
            endcase
        end
        ram_rd <= ram[widx];
    end

    always @(negedge clk) begin
        if (bus.mem_write === 1'b1) wr_cycles <= wr_cycles + 1;
    end

    function automatic txn_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic mi,
                                input logic fa, input int la, input int wr);
        txn_t t;
        t.write = w;  t.funct3 = f3; t.addr = a;   t.wdata = wd; t.rdata = rd;
        t.mis   = mi; t.fault  = fa; t.lat  = la;  t.wr    = wr;
        return t;
    endfunction

    // Issues one request from idle, waits (bounded) for the response and completes the
    // handshake. lat counts cycles from acceptance to the first resp_valid cycle (-1: timeout).
    task automatic do_req(input txn_t t, output logic [31:0] rd, output logic mi,
                          output logic fa, output int lat, output int wr);
        int wr0;
        wr0 = wr_cycles;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = t.write;
        bus.req_funct3 = t.funct3;
        bus.req_addr   = t.addr;
        bus.req_wdata  = t.wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        rd = bus.resp_rdata;
        mi = bus.resp_misaligned;
        fa = bus.resp_fault;
        if (lat > 0) begin
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1 bus.resp_ready = 1'b0;
        end
        @(negedge clk);
        wr = wr_cycles - wr0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.resp_fault,
             bus.mem_write} !== 5'b10000 || bus.resp_rdata !== 32'h0
            || bus.mem_address !== 6'h0 || bus.mem_w_data !== 32'h0 || bus.mem_funct3 !== 3'h0)
        begin
            bad++;
            $display("FAIL reset: rdy=%b rv=%b mis=%b flt=%b mw=%b rdata=%h addr=%h wd=%h f3=%h, want 1 0 0 0 0 and zeros",
                     bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.resp_fault,
                     bus.mem_write, bus.resp_rdata, bus.mem_address, bus.mem_w_data,
                     bus.mem_funct3);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load_word();
        txn_t tv[$];
        txn_t e;
        logic [31:0] rd;
        logic mi, fa;
        int la, wr;
        tv.push_back(mk(1, 3'd2, 32'h08, 32'hDEADBEEF, 32'h0, 0, 0, 2, 1));
        tv.push_back(mk(0, 3'd2, 32'h08, 32'h0, 32'hDEADBEEF, 0, 0, 3, 0));
        foreach (tv[i]) begin
            exp_q.push_back(tv[i]);
            do_req(tv[i], rd, mi, fa, la, wr);
            e = exp_q.pop_front();
            total++;
            if (rd !== e.rdata || mi !== e.mis || fa !== e.fault || la != e.lat || wr != e.wr) begin
                bad++;
                $display("FAIL word[%0d]: rdata=%h mis=%b flt=%b lat=%0d wr=%0d, want %h %b %b %0d %0d",
                         i, rd, mi, fa, la, wr, e.rdata, e.mis, e.fault, e.lat, e.wr);
            end
        end
    endtask

    task automatic test_subword();
        txn_t tv[$];
        txn_t e;
        logic [31:0] rd;
        logic mi, fa;
        int la, wr;
        tv.push_back(mk(1, 3'd0, 32'h0B, 32'h1234565A, 32'h0, 0, 0, 2, 1));       // SB
        tv.push_back(mk(0, 3'd0, 32'h0B, 32'h0, 32'h0000005A, 0, 0, 3, 0));       // LB
        tv.push_back(mk(0, 3'd4, 32'h08, 32'h0, 32'h000000EF, 0, 0, 3, 0));       // LBU
        tv.push_back(mk(0, 3'd0, 32'h08, 32'h0, 32'hFFFFFFEF, 0, 0, 3, 0));       // LB
        tv.push_back(mk(0, 3'd0, 32'h0A, 32'h0, 32'hFFFFFFAD, 0, 0, 3, 0));       // LB
        tv.push_back(mk(0, 3'd1, 32'h0A, 32'h0, 32'h00005AAD, 0, 0, 3, 0));       // LH
        tv.push_back(mk(0, 3'd1, 32'h08, 32'h0, 32'hFFFFBEEF, 0, 0, 3, 0));       // LH
        tv.push_back(mk(0, 3'd5, 32'h08, 32'h0, 32'h0000BEEF, 0, 0, 3, 0));       // LHU
        tv.push_back(mk(1, 3'd1, 32'h06, 32'hFFFF5ABE, 32'h0, 0, 0, 2, 1));       // SH
        tv.push_back(mk(0, 3'd2, 32'h04, 32'h0, 32'h5ABE0000, 0, 0, 3, 0));       // LW
        tv.push_back(mk(0, 3'd5, 32'h06, 32'h0, 32'h00005ABE, 0, 0, 3, 0));       // LHU
        foreach (tv[i]) begin
            exp_q.push_back(tv[i]);
            do_req(tv[i], rd, mi, fa, la, wr);
            e = exp_q.pop_front();
            total++;
            if (rd !== e.rdata || mi !== e.mis || fa !== e.fault || la != e.lat || wr != e.wr) begin
                bad++;
                $display("FAIL subword[%0d]: rdata=%h mis=%b flt=%b lat=%0d wr=%0d, want %h %b %b %0d %0d",
                         i, rd, mi, fa, la, wr, e.rdata, e.mis, e.fault, e.lat, e.wr);
            end
        end
    endtask

    task automatic test_misaligned_fault();
        txn_t tv[$];
        txn_t e;
        logic [31:0] rd;
        logic mi, fa;
        int la, wr;
        tv.push_back(mk(0, 3'd2, 32'h06, 32'h0, 32'h0, 1, 0, 1, 0));              // LW mis
        tv.push_back(mk(0, 3'd1, 32'h07, 32'h0, 32'h0, 1, 0, 1, 0));              // LH mis
        tv.push_back(mk(1, 3'd2, 32'h0A, 32'h01020304, 32'h0, 1, 0, 1, 0));       // SW mis
        tv.push_back(mk(1, 3'd1, 32'h09, 32'h01020304, 32'h0, 1, 0, 1, 0));       // SH mis
        tv.push_back(mk(0, 3'd2, 32'h40, 32'h0, 32'h0, 0, 1, 1, 0));              // LW fault
        tv.push_back(mk(1, 3'd2, 32'h100, 32'h01020304, 32'h0, 0, 1, 1, 0));      // SW fault
        tv.push_back(mk(0, 3'd3, 32'h00, 32'h0, 32'h0, 1, 0, 1, 0));              // bad load f3
        tv.push_back(mk(1, 3'd4, 32'h00, 32'h01020304, 32'h0, 1, 0, 1, 0));       // bad store f3
        tv.push_back(mk(0, 3'd2, 32'h41, 32'h0, 32'h0, 1, 1, 1, 0));              // both
        tv.push_back(mk(0, 3'd2, 32'h08, 32'h0, 32'h5AADBEEF, 0, 0, 3, 0));       // untouched
        foreach (tv[i]) begin
            exp_q.push_back(tv[i]);
            do_req(tv[i], rd, mi, fa, la, wr);
            e = exp_q.pop_front();
            total++;
            if (rd !== e.rdata || mi !== e.mis || fa !== e.fault || la != e.lat || wr != e.wr) begin
                bad++;
                $display("FAIL misfault[%0d]: rdata=%h mis=%b flt=%b lat=%0d wr=%0d, want %h %b %b %0d %0d",
                         i, rd, mi, fa, la, wr, e.rdata, e.mis, e.fault, e.lat, e.wr);
            end
        end
    endtask

    task automatic test_backpressure();
        txn_t e;
        int lat;
        int wr0;
        exp_q.push_back(mk(0, 3'd2, 32'h08, 32'h0, 32'h5AADBEEF, 0, 0, 3, 0));
        wr0 = wr_cycles;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h08;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        e = exp_q.pop_front();
        total++;
        if (lat != e.lat || bus.resp_rdata !== e.rdata) begin
            bad++;
            $display("FAIL bp_first: lat=%0d rdata=%h, want %0d %h", lat, bus.resp_rdata,
                     e.lat, e.rdata);
        end
        // A competing store is offered while the response is held.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h00;
        bus.req_wdata  = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata || bus.req_ready !== 1'b0)
            begin
                bad++;
                $display("FAIL bp_hold[%0d]: rv=%b rdata=%h rdy=%b, want 1 %h 0", c,
                         bus.resp_valid, bus.resp_rdata, bus.req_ready, e.rdata);
            end
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || wr_cycles != wr0) begin
            bad++;
            $display("FAIL bp_release: rv=%b rdy=%b writes=%0d, want 0 1 0", bus.resp_valid,
                     bus.req_ready, wr_cycles - wr0);
        end
    endtask

    task automatic test_reset_mid_access();
        txn_t tv[$];
        txn_t e;
        logic [31:0] rd;
        logic mi, fa;
        int la, wr;
        tv.push_back(mk(1, 3'd2, 32'h0C, 32'hCAFEF00D, 32'h0, 0, 0, 2, 1));
        tv.push_back(mk(0, 3'd2, 32'h0C, 32'h0, 32'hCAFEF00D, 0, 0, 3, 0));
        foreach (tv[i]) begin
            if (i == 1) begin
                // Start SW 0x11223344 @0x0C and reset during its ACCESS cycle.
                @(negedge clk);
                bus.req_valid  = 1'b1;
                bus.req_write  = 1'b1;
                bus.req_funct3 = 3'd2;
                bus.req_addr   = 32'h0C;
                bus.req_wdata  = 32'h11223344;
                @(posedge clk);
                #1 bus.req_valid = 1'b0;
                @(negedge clk);
                total++;
                if (bus.mem_write !== 1'b1 || bus.mem_address !== 6'h0C) begin
                    bad++;
                    $display("FAIL rst_access: mw=%b addr=%h, want 1 0c", bus.mem_write,
                             bus.mem_address);
                end
                rst = 1'b1;
                #1;
                total++;
                if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
                begin
                    bad++;
                    $display("FAIL rst_async: mw=%b rdy=%b rv=%b, want 0 1 0", bus.mem_write,
                             bus.req_ready, bus.resp_valid);
                end
                @(negedge clk);
                rst = 1'b0;
            end
            exp_q.push_back(tv[i]);
            do_req(tv[i], rd, mi, fa, la, wr);
            e = exp_q.pop_front();
            total++;
            if (rd !== e.rdata || mi !== e.mis || fa !== e.fault || la != e.lat || wr != e.wr) begin
                bad++;
                $display("FAIL rst_txn[%0d]: rdata=%h mis=%b flt=%b lat=%0d wr=%0d, want %h %b %b %0d %0d",
                         i, rd, mi, fa, la, wr, e.rdata, e.mis, e.fault, e.lat, e.wr);
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_store_load_word();
        test_subword();
        test_misaligned_fault();
        test_backpressure();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end
endmodule
